mem_arbiter: RTL and testbench

- Two-port request arbiter directly upstream of the memory unit. It multiplexes the CPU instruction-fetch port (A) and data port (B) onto the single memory-unit bus.
- Drives the memory unit's address/data/we/start and runs its start/busy handshake: start held high until busy has risen and then fallen.
- Returns read data and a one-cycle ack to the granted port. Round-robin arbitration; a timeout recovers from a hung transaction.

---
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that puts the instruction-fetch port (A) and the data port (B)
// onto the single memory-unit bus, running its start/busy handshake with a timeout.
module mem_arbiter #(
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init_done,
    input  logic        a_req,
    input  logic [26:0] a_addr,
    output logic        a_ack,
    output logic [31:0] a_q,
    input  logic        b_req,
    input  logic [26:0] b_addr,
    input  logic [31:0] b_data,
    input  logic        b_we,
    output logic        b_ack,
    output logic [31:0] b_q,
    output logic [26:0] bus_addr,
    output logic [31:0] bus_data,
    output logic        bus_we,
    output logic        bus_start,
    input  logic        bus_busy,
    input  logic [31:0] bus_q,
    output logic        timeout_err,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic             grant_b;
    logic             last_grant_b;
    logic [CNT_W-1:0] cnt;

    logic             pick_b;
    logic             timed_out;
    logic             finish;
    logic [31:0]      fin_q;

    // Handshake (both ports): req rises with addr/data/we valid and stays high
    // until the one-cycle ack; fields are captured at grant, so later changes
    // are ignored. A req still high in the IDLE after DONE is a new request.
    always_comb begin
        pick_b    = b_req && (!a_req || !last_grant_b);
        timed_out = (state == S_ISSUE || state == S_WAIT) && (cnt == CNT_LAST);
        finish    = timed_out || (state == S_WAIT && !bus_busy);
        fin_q     = timed_out ? 32'd0 : bus_q;
    end

    assign fsm_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            grant_b      <= 1'b0;
            last_grant_b <= 1'b1;
            cnt          <= '0;
            a_ack        <= 1'b0;
            a_q          <= 32'd0;
            b_ack        <= 1'b0;
            b_q          <= 32'd0;
            bus_addr     <= 27'd0;
            bus_data     <= 32'd0;
            bus_we       <= 1'b0;
            bus_start    <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (init_done && (a_req || b_req)) begin
                        grant_b   <= pick_b;
                        bus_addr  <= pick_b ? b_addr : a_addr;
                        bus_data  <= pick_b ? b_data : 32'd0;
                        bus_we    <= pick_b && b_we;
                        bus_start <= 1'b1;
                        cnt       <= '0;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE, S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (finish) begin
                        // Bus is parked at zero outside a transaction: the memory
                        // unit decodes I/O writes from the address combinationally.
                        bus_start   <= 1'b0;
                        bus_addr    <= 27'd0;
                        bus_data    <= 32'd0;
                        bus_we      <= 1'b0;
                        timeout_err <= timed_out;
                        if (grant_b) begin
                            b_ack <= 1'b1;
                            b_q   <= fin_q;
                        end else begin
                            a_ack <= 1'b1;
                            a_q   <= fin_q;
                        end
                        state <= S_DONE;
                    end else if (state == S_ISSUE && bus_busy) begin
                        state <= S_WAIT;
                    end
                end
                S_DONE: begin
                    last_grant_b <= grant_b;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a negedge memory-unit model answers bus_start,
// and each scenario task checks handshake timing, arbitration order and data.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        init_done = 1'b1;
    logic        a_req = 1'b0;
    logic [26:0] a_addr = '0;
    logic        a_ack;
    logic [31:0] a_q;
    logic        b_req = 1'b0;
    logic [26:0] b_addr = '0;
    logic [31:0] b_data = '0;
    logic        b_we = 1'b0;
    logic        b_ack;
    logic [31:0] b_q;
    logic [26:0] bus_addr;
    logic [31:0] bus_data;
    logic        bus_we;
    logic        bus_start;
    logic        bus_busy = 1'b0;
    logic [31:0] bus_q = '0;
    logic        timeout_err;
    logic [1:0]  fsm_state;

    int n_tests = 0;
    int n_fail  = 0;

    // memory-unit model controls
    int          m_phase = 0;
    int          m_cnt = 0;
    int          m_lat = 0;
    bit          m_hang = 1'b0;
    bit          m_use_addr = 1'b0;
    logic [31:0] m_resp = '0;

    mem_arbiter #(.TIMEOUT(16), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .init_done(init_done),
        .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_q(a_q),
        .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_we(b_we),
        .b_ack(b_ack), .b_q(b_q),
        .bus_addr(bus_addr), .bus_data(bus_data), .bus_we(bus_we),
        .bus_start(bus_start), .bus_busy(bus_busy), .bus_q(bus_q),
        .timeout_err(timeout_err), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    // busy rises one negedge after start, falls m_lat negedges later
    always @(negedge clk) begin
        if (!reset) begin
            bus_busy = 1'b0;
            m_phase  = 0;
        end else begin
            case (m_phase)
                0: if (bus_start) begin
                    bus_busy = 1'b1;
                    m_cnt    = m_lat;
                    m_phase  = 1;
                end
                1: if (!m_hang) begin
                    if (m_cnt == 0) begin
                        bus_busy = 1'b0;
                        bus_q    = m_use_addr ? (32'hA500_0000 ^ {5'd0, bus_addr}) : m_resp;
                        m_phase  = 2;
                    end else begin
                        m_cnt = m_cnt - 1;
                    end
                end
                default: if (!bus_start) m_phase = 0;
            endcase
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        a_req = 1'b0; b_req = 1'b0; b_we = 1'b0;
        m_hang = 1'b0; m_lat = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({bus_start, bus_we, a_ack, b_ack, timeout_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 00000", {bus_start, bus_we, a_ack, b_ack, timeout_err});
        end
        n_tests++;
        if (bus_addr !== 27'd0 || bus_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_bus: addr %h data %h want 0", bus_addr, bus_data);
        end
        n_tests++;
        if (a_q !== 32'd0 || b_q !== 32'd0 || fsm_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_q: a_q %h b_q %h state %0d want 0", a_q, b_q, fsm_state);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus_start !== 1'b0 || fsm_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_idle: start %b state %0d want 0/0", bus_start, fsm_state);
        end
    endtask

    task automatic test_single_a();
        m_resp = 32'hDEADBEEF; m_use_addr = 1'b0; m_lat = 0;
        a_addr = 27'hC00010;
        a_req  = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus_start !== 1'b1 || bus_addr !== 27'hC00010 || bus_we !== 1'b0) begin
            n_fail++;
            $display("FAIL single_c1: start %b addr %h we %b want 1 c00010 0", bus_start, bus_addr, bus_we);
        end
        @(negedge clk);
        n_tests++;
        if (bus_start !== 1'b1 || a_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL single_c2: start %b ack %b want 1 0", bus_start, a_ack);
        end
        @(negedge clk);
        n_tests++;
        if (a_ack !== 1'b1 || a_q !== 32'hDEADBEEF || bus_start !== 1'b0 || bus_addr !== 27'd0) begin
            n_fail++;
            $display("FAIL single_c3: ack %b q %h start %b addr %h want 1 deadbeef 0 0",
                     a_ack, a_q, bus_start, bus_addr);
        end
        a_req = 1'b0;
        a_addr = 27'h3FF;
        @(negedge clk);
        n_tests++;
        if (a_ack !== 1'b0 || bus_start !== 1'b0 || bus_addr !== 27'd0 || a_q !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL single_c4: ack %b start %b addr %h q %h want 0 0 0 deadbeef",
                     a_ack, bus_start, bus_addr, a_q);
        end
    endtask

    task automatic test_both();
        int cyc_a = -1;
        int cyc_b = -1;
        int field_err = 0;
        int start_cnt = 0;
        int extra = 0;
        logic [31:0] qa = '0;
        do_reset();
        m_resp = 32'h1111_2222; m_use_addr = 1'b0; m_lat = 0;
        @(negedge clk);
        a_addr = 27'h40; b_addr = 27'h100; b_data = 32'h12345678; b_we = 1'b1;
        a_req = 1'b1; b_req = 1'b1;
        for (int c = 1; c <= 30 && (cyc_a < 0 || cyc_b < 0); c++) begin
            @(negedge clk);
            if (bus_start) begin
                start_cnt++;
                if (bus_addr == 27'h100) begin
                    if (!bus_we || bus_data != 32'h12345678) field_err++;
                end else if (bus_we || bus_data != 32'd0) begin
                    field_err++;
                end
            end else if (bus_we || bus_data != 32'd0) begin
                field_err++;
            end
            if (a_ack) begin
                if (cyc_a < 0) cyc_a = c; else extra++;
                qa = a_q;
                a_req = 1'b0;
            end
            if (b_ack) begin
                if (cyc_b < 0) cyc_b = c; else extra++;
                b_req = 1'b0;
            end
        end
        repeat (4) begin
            @(negedge clk);
            if (a_ack || b_ack) extra++;
        end
        b_we = 1'b0;
        n_tests++;
        if (cyc_a != 3 || cyc_b != 7) begin
            n_fail++;
            $display("FAIL both_order: a_ack cycle %0d b_ack cycle %0d want 3 7", cyc_a, cyc_b);
        end
        n_tests++;
        if (field_err != 0 || start_cnt != 4) begin
            n_fail++;
            $display("FAIL both_bus: field errors %0d start cycles %0d want 0 4", field_err, start_cnt);
        end
        n_tests++;
        if (extra != 0 || qa !== 32'h1111_2222) begin
            n_fail++;
            $display("FAIL both_acks: extra acks %0d a_q %h want 0 11112222", extra, qa);
        end
    endtask

    task automatic test_alternate();
        int order[$];
        int q_err = 0;
        do_reset();
        m_use_addr = 1'b1; m_lat = 0;
        @(negedge clk);
        a_addr = 27'h10; b_addr = 27'h20; b_we = 1'b0;
        a_req = 1'b1; b_req = 1'b1;
        for (int c = 0; c < 60 && order.size() < 6; c++) begin
            @(negedge clk);
            if (a_ack) begin
                order.push_back(0);
                if (a_q !== 32'hA500_0010) q_err++;
            end
            if (b_ack) begin
                order.push_back(1);
                if (b_q !== 32'hA500_0020) q_err++;
            end
            if (order.size() >= 6) begin
                a_req = 1'b0; b_req = 1'b0;
            end
        end
        a_req = 1'b0; b_req = 1'b0;
        n_tests++;
        if (order.size() != 6 || q_err != 0) begin
            n_fail++;
            $display("FAIL alt_count: acks %0d q errors %0d want 6 0", order.size(), q_err);
        end
        for (int i = 0; i < order.size(); i++) begin
            n_tests++;
            if (order[i] != (i % 2)) begin
                n_fail++;
                $display("FAIL alt_grant%0d: port %0d want %0d", i, order[i], i % 2);
            end
        end
        m_use_addr = 1'b0;
    endtask

    task automatic test_timeout();
        int starts = 0;
        int ack_seen = 0;
        logic err_at_ack = 1'b0;
        logic start_at_ack = 1'b1;
        logic [31:0] q_at_ack = 32'hFFFF_FFFF;
        do_reset();
        m_hang = 1'b1;
        @(negedge clk);
        a_addr = 27'h55;
        a_req = 1'b1;
        for (int c = 0; c < 40 && ack_seen == 0; c++) begin
            @(negedge clk);
            if (bus_start) starts++;
            if (a_ack) begin
                ack_seen = 1;
                err_at_ack = timeout_err;
                start_at_ack = bus_start;
                q_at_ack = a_q;
                a_req = 1'b0;
            end
        end
        m_hang = 1'b0;
        n_tests++;
        if (ack_seen != 1 || starts != 16) begin
            n_fail++;
            $display("FAIL timeout_len: ack %0d start cycles %0d want 1 16", ack_seen, starts);
        end
        n_tests++;
        if (err_at_ack !== 1'b1 || start_at_ack !== 1'b0 || q_at_ack !== 32'd0) begin
            n_fail++;
            $display("FAIL timeout_ack: err %b start %b q %h want 1 0 0", err_at_ack, start_at_ack, q_at_ack);
        end
        @(negedge clk);
        n_tests++;
        if (timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pulse: err %b want 0", timeout_err);
        end
        repeat (3) @(negedge clk);
        m_resp = 32'hCAFEF00D;
        a_req = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (a_ack !== 1'b1 || a_q !== 32'hCAFEF00D || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_next: ack %b q %h err %b want 1 cafef00d 0", a_ack, a_q, timeout_err);
        end
        a_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int bad_ack = 0;
        do_reset();
        m_lat = 3; m_resp = 32'h0BAD_F00D;
        @(negedge clk);
        a_addr = 27'h77;
        a_req = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        n_tests++;
        if (bus_start !== 1'b0 || bus_addr !== 27'd0 || a_ack !== 1'b0 || fsm_state !== 2'd0) begin
            n_fail++;
            $display("FAIL rstmid_now: start %b addr %h ack %b state %0d want 0 0 0 0",
                     bus_start, bus_addr, a_ack, fsm_state);
        end
        m_lat = 0;
        repeat (2) begin
            @(negedge clk);
            if (a_ack || bus_start) bad_ack++;
        end
        reset = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (a_ack && c != 3) bad_ack++;
            if (c == 3) begin
                n_tests++;
                if (a_ack !== 1'b1 || a_q !== 32'h0BAD_F00D) begin
                    n_fail++;
                    $display("FAIL rstmid_reserve: ack %b q %h want 1 0badf00d", a_ack, a_q);
                end
                a_req = 1'b0;
            end
        end
        n_tests++;
        if (bad_ack != 0) begin
            n_fail++;
            $display("FAIL rstmid_spurious: stray events %0d want 0", bad_ack);
        end
    endtask

    task automatic test_init_done();
        int starts = 0;
        do_reset();
        init_done = 1'b0;
        m_resp = 32'h600D_0001;
        @(negedge clk);
        a_addr = 27'h9;
        a_req = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus_start || a_ack) starts++;
        end
        n_tests++;
        if (starts != 0) begin
            n_fail++;
            $display("FAIL init_hold: start/ack cycles %0d want 0", starts);
        end
        init_done = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus_start !== 1'b1) begin
            n_fail++;
            $display("FAIL init_start: start %b want 1", bus_start);
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (a_ack !== 1'b1 || a_q !== 32'h600D_0001) begin
            n_fail++;
            $display("FAIL init_ack: ack %b q %h want 1 600d0001", a_ack, a_q);
        end
        a_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_both();
        test_alternate();
        test_timeout();
        test_reset_mid();
        test_init_done();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
